// File: rtl/audio_out_axil_regs_pkg.sv
// audio_out_pkg: constants and types shared by the audio_out AXI4-Lite
// register block.
//   - AXI response codes (RESP_OKAY, RESP_SLVERR)
//   - register slot indices (REG_CTRL, REG_VOL, REG_RATE, REG_AUX)
//   - write/read channel FSM state enums
//   - slot_mapped(): true for word slots backed by a real register
package audio_out_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_VOL  = 2'd1;
    localparam logic [1:0] REG_RATE = 2'd2;
    localparam logic [1:0] REG_AUX  = 2'd3;

    localparam int unsigned N_REGS = 4;

    // Word slot decoded from ADDR[4:2]; slots 4-7 are unmapped.
    typedef logic [2:0] slot_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_GOT_AW,
        W_GOT_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    function automatic logic slot_mapped(input slot_t slot);
        return ({29'd0, slot} < N_REGS);
    endfunction

endpackage

// File: rtl/audio_out_axil_regs_if.sv
// audio_out_axil_regs_if: AXI4-Lite (S00_AXI) bus bundle for the audio_out
// register block. Signal names follow the AXI slave port names.
//   master modport: drives AW/W/AR channels and BREADY/RREADY
//   slave  modport: drives the READY of AW/W/AR and the B/R channels
interface audio_out_axil_regs_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);

    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

// File: rtl/audio_out_axil_regs_strb_merge.sv
// audio_out_strb_merge: combinational byte-lane merge for one register write.
//   old_word : current register contents
//   new_word : incoming write data
//   strb     : byte enables, strb[k] selects new_word byte k
//   merged   : resulting register value
module audio_out_strb_merge #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged
);

    always_comb begin
        merged = old_word;
        for (int unsigned k = 0; k < DATA_W / 8; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/audio_out_axil_regs.sv
// audio_out_axil_regs: AXI4-Lite responder holding the four audio_out control
// registers (CTRL, VOL, RATE, AUX at byte offsets 0x0/0x4/0x8/0xC).
//   S_AXI_ACLK    : clock
//   S_AXI_ARESETN : asynchronous active-low reset
//   s_axi         : S00_AXI slave bus (audio_out_axil_regs_if.slave)
//   reg0_o..reg3_o: register contents to the audio datapath
//   wr_pulse_o    : one-hot, high for one cycle after register n is written
// Build option: define AUDIO_OUT_SLVERR_EN to answer accesses to unmapped
// slots 4-7 with SLVERR instead of OKAY.
module audio_out_axil_regs
    import audio_out_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    audio_out_axil_regs_if.slave          s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
    output logic [N_REGS-1:0]             wr_pulse_o
);

`ifdef AUDIO_OUT_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif

    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

    // Registered channel outputs
    logic                          awready_q;
    logic                          wready_q;
    logic                          bvalid_q;
    logic [1:0]                    bresp_q;
    logic                          arready_q;
    logic                          rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                    rresp_q;

    wr_state_t wstate;
    rd_state_t rstate;

    // Halves of a write that arrived ahead of their partner
    slot_t                         awslot_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]             wstrb_q;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs   [N_REGS];
    logic [C_S_AXI_DATA_WIDTH-1:0] merged [N_REGS];
    logic [N_REGS-1:0]             wr_pulse_q;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    slot_t                         aw_slot;
    slot_t                         ar_slot;

    // Effective write once both halves are available
    logic                          wr_en;
    slot_t                         wr_slot;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]             wr_strb;
    logic                          wr_mapped;
    logic [N_REGS-1:0]             wr_sel;

    logic                          unused_bits;

    assign aw_slot = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_slot = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign aw_hs   = s_axi.S_AXI_AWVALID & awready_q;
    assign w_hs    = s_axi.S_AXI_WVALID & wready_q;
    assign ar_hs   = s_axi.S_AXI_ARVALID & arready_q;

    // Byte offset and protection bits carry no meaning for this block
    assign unused_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                           s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

    // Pick address/data from the live bus or the latched half, depending on
    // which half arrived first; wr_en marks the cycle the pair completes.
    always_comb begin
        wr_en   = 1'b0;
        wr_slot = aw_slot;
        wr_data = s_axi.S_AXI_WDATA;
        wr_strb = s_axi.S_AXI_WSTRB;
        unique case (wstate)
            W_IDLE:   wr_en = aw_hs & w_hs;
            W_GOT_AW: begin
                wr_en   = w_hs;
                wr_slot = awslot_q;
            end
            W_GOT_W:  begin
                wr_en   = aw_hs;
                wr_data = wdata_q;
                wr_strb = wstrb_q;
            end
            default:  wr_en = 1'b0;
        endcase
    end

    assign wr_mapped = slot_mapped(wr_slot);

    always_comb begin
        wr_sel = '0;
        if (wr_en && wr_mapped) begin
            wr_sel[wr_slot[1:0]] = 1'b1;
        end
    end

    // Write channel FSM
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate    <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awslot_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else if (wr_en) begin
            wstate    <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= (!wr_mapped && SLVERR_EN) ? RESP_SLVERR : RESP_OKAY;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    // Readies come up here on the first cycle out of reset
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    if (aw_hs) begin
                        awslot_q  <= aw_slot;
                        awready_q <= 1'b0;
                        wstate    <= W_GOT_AW;
                    end else if (w_hs) begin
                        wdata_q  <= s_axi.S_AXI_WDATA;
                        wstrb_q  <= s_axi.S_AXI_WSTRB;
                        wready_q <= 1'b0;
                        wstate   <= W_GOT_W;
                    end
                end
                W_GOT_AW: ;
                W_GOT_W:  ;
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate    <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_merge
        audio_out_strb_merge #(
            .DATA_W (C_S_AXI_DATA_WIDTH)
        ) u_merge (
            .old_word (regs[g]),
            .new_word (wr_data),
            .strb     (wr_strb),
            .merged   (merged[g])
        );
    end

    // Register file and write strobes
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int unsigned n = 0; n < N_REGS; n++) begin
                regs[n] <= '0;
            end
            wr_pulse_q <= '0;
        end else begin
            for (int unsigned n = 0; n < N_REGS; n++) begin
                if (wr_sel[n]) begin
                    regs[n] <= merged[n];
                end
            end
            wr_pulse_q <= wr_sel;
        end
    end

    // Read channel FSM; sampling regs here returns the pre-write value when a
    // write to the same register lands on the same edge.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rstate    <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        if (slot_mapped(ar_slot)) begin
                            rdata_q <= regs[ar_slot[1:0]];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= SLVERR_EN ? RESP_SLVERR : RESP_OKAY;
                        end
                        rstate <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi.S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate    <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    assign reg0_o     = regs[REG_CTRL];
    assign reg1_o     = regs[REG_VOL];
    assign reg2_o     = regs[REG_RATE];
    assign reg3_o     = regs[REG_AUX];
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_audio_out_axil_regs.sv
// tb_audio_out_axil_regs: bench for audio_out_axil_regs. Expected write and
// read responses are pushed to per-channel queues when a transaction is
// issued and popped when the DUT responds.
// Build option: AUDIO_OUT_SLVERR_EN (must match the RTL build).
module tb_audio_out_axil_regs;
    import audio_out_pkg::*;

`ifdef AUDIO_OUT_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif
    localparam int BOUND = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    audio_out_axil_regs_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    logic [31:0] reg0, reg1, reg2, reg3;
    logic [3:0]  wr_pulse;

    audio_out_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus),
        .reg0_o        (reg0),
        .reg1_o        (reg1),
        .reg2_o        (reg2),
        .reg3_o        (reg3),
        .wr_pulse_o    (wr_pulse)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  pulse;
    } exp_t;

    exp_t        wq[$];
    exp_t        rq[$];
    logic [31:0] model [4];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_merge(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    task automatic expect_write(input logic [4:0] addr, input logic [31:0] data,
                                input logic [3:0] strb);
        exp_t        e;
        logic [2:0]  slot;
        slot = addr[4:2];
        e.data = data;
        if (slot < 3'd4) begin
            model[slot[1:0]] = model_merge(model[slot[1:0]], data, strb);
            e.resp  = 2'b00;
            e.pulse = 4'b0001 << slot[1:0];
        end else begin
            e.resp  = UNMAPPED_RESP;
            e.pulse = 4'b0000;
        end
        wq.push_back(e);
    endtask

    task automatic expect_read(input logic [4:0] addr);
        exp_t       e;
        logic [2:0] slot;
        slot    = addr[4:2];
        e.pulse = 4'b0000;
        if (slot < 3'd4) begin
            e.data = model[slot[1:0]];
            e.resp = 2'b00;
        end else begin
            e.data = 32'h0;
            e.resp = UNMAPPED_RESP;
        end
        rq.push_back(e);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_reg0"}, reg0, model[0]);
        check({tag, "_reg1"}, reg1, model[1]);
        check({tag, "_reg2"}, reg2, model[2]);
        check({tag, "_reg3"}, reg3, model[3]);
    endtask

    // Entered at the negedge right after the last of AW/W handshook.
    task automatic finish_write(input int hold);
        exp_t e;
        int   t;
        if (wq.size() == 0) begin
            check("wr_sb_empty", 32'd1, 32'd0);
            return;
        end
        e = wq.pop_front();
        check("bvalid_latency", bus.S_AXI_BVALID, 1'b1);
        check("wr_pulse", wr_pulse, e.pulse);
        repeat (hold) begin
            @(negedge clk);
            check("bvalid_hold", bus.S_AXI_BVALID, 1'b1);
            check("bresp_hold", bus.S_AXI_BRESP, e.resp);
            check("awready_blocked", bus.S_AXI_AWREADY, 1'b0);
            check("wr_pulse_single", wr_pulse, 4'b0000);
        end
        bus.S_AXI_BREADY = 1'b1;
        t = 0;
        while (!bus.S_AXI_BVALID && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        check("bvalid_bound", t < BOUND, 1'b1);
        check("bresp", bus.S_AXI_BRESP, e.resp);
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        check("bvalid_clear", bus.S_AXI_BVALID, 1'b0);
        check("awready_after_b", bus.S_AXI_AWREADY, 1'b1);
        check("wr_pulse_gone", wr_pulse, 4'b0000);
    endtask

    task automatic drive_write(input logic [4:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int hold);
        logic aw_f, w_f;
        int   t;
        @(negedge clk);
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_WVALID  = 1'b1;
        t = 0;
        while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && t < BOUND) begin
            aw_f = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_f  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(negedge clk);
            if (aw_f) bus.S_AXI_AWVALID = 1'b0;
            if (w_f)  bus.S_AXI_WVALID  = 1'b0;
            t++;
        end
        check("wr_hs_bound", t < BOUND, 1'b1);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        finish_write(hold);
    endtask

    task automatic drive_read(input logic [4:0] addr, input int hold);
        exp_t e;
        logic ar_f;
        int   t;
        @(negedge clk);
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        t = 0;
        while (bus.S_AXI_ARVALID && t < BOUND) begin
            ar_f = bus.S_AXI_ARREADY;
            @(negedge clk);
            if (ar_f) bus.S_AXI_ARVALID = 1'b0;
            t++;
        end
        check("rd_hs_bound", t < BOUND, 1'b1);
        bus.S_AXI_ARVALID = 1'b0;
        if (rq.size() == 0) begin
            check("rd_sb_empty", 32'd1, 32'd0);
            return;
        end
        e = rq.pop_front();
        check("rvalid_latency", bus.S_AXI_RVALID, 1'b1);
        repeat (hold) begin
            @(negedge clk);
            check("rvalid_hold", bus.S_AXI_RVALID, 1'b1);
            check("rdata_hold", bus.S_AXI_RDATA, e.data);
            check("rresp_hold", bus.S_AXI_RRESP, e.resp);
            check("arready_blocked", bus.S_AXI_ARREADY, 1'b0);
        end
        bus.S_AXI_RREADY = 1'b1;
        check("rdata", bus.S_AXI_RDATA, e.data);
        check("rresp", bus.S_AXI_RRESP, e.resp);
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
        check("rvalid_clear", bus.S_AXI_RVALID, 1'b0);
    endtask

    task automatic write_read(input logic [4:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
        expect_write(addr, data, strb);
        drive_write(addr, data, strb, 0);
        expect_read(addr);
        drive_read(addr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1_data [4];
        int          t;
        t1_data = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
        for (int i = 0; i < 4; i++) model[i] = 32'h0;

        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWPROT  = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WSTRB   = '0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARPROT  = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #22;
        check("rst_awready", bus.S_AXI_AWREADY, 1'b0);
        check("rst_wready",  bus.S_AXI_WREADY,  1'b0);
        check("rst_arready", bus.S_AXI_ARREADY, 1'b0);
        check("rst_bvalid",  bus.S_AXI_BVALID,  1'b0);
        check("rst_rvalid",  bus.S_AXI_RVALID,  1'b0);
        check("rst_bresp",   bus.S_AXI_BRESP,   2'b00);
        check("rst_rresp",   bus.S_AXI_RRESP,   2'b00);
        check("rst_rdata",   bus.S_AXI_RDATA,   32'h0);
        check("rst_pulse",   wr_pulse,          4'b0000);
        check_regs("rst");
        #4 rst_n = 1'b1;

        // Write then read back each register
        for (int i = 0; i < 4; i++) begin
            logic [4:0] a;
            a = 5'(i * 4);
            write_read(a, t1_data[i], 4'hF);
        end
        check_regs("basic");
        check("basic_reg3_const", reg3, 32'hBEEF0011);

        // AW three cycles ahead of W
        expect_write(5'h04, 32'h12345678, 4'hF);
        @(negedge clk);
        bus.S_AXI_AWADDR  = 5'h04;
        bus.S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!bus.S_AXI_AWREADY && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        check("aw_early_bound", t < BOUND, 1'b1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        check("awready_after_aw", bus.S_AXI_AWREADY, 1'b0);
        check("wready_waiting", bus.S_AXI_WREADY, 1'b1);
        repeat (2) begin
            check("bvalid_before_w", bus.S_AXI_BVALID, 1'b0);
            @(negedge clk);
        end
        bus.S_AXI_WDATA  = 32'h12345678;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        check("wready_at_w", bus.S_AXI_WREADY, 1'b1);
        check("bvalid_at_w", bus.S_AXI_BVALID, 1'b0);
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0;
        check("aw_early_pulse", wr_pulse, 4'b0010);
        check("aw_early_reg1", reg1, 32'h12345678);
        finish_write(0);

        // Byte strobes
        write_read(5'h00, 32'hFFFFFFFF, 4'hF);
        write_read(5'h00, 32'h00AA0055, 4'b0101);
        check("strb_reg0_const", reg0, 32'hFFAAFF55);
        write_read(5'h08, 32'h00000000, 4'b0000);
        check_regs("strb");

        // Back-pressure on B and R
        expect_write(5'h0C, 32'hC0FFEE01, 4'hF);
        drive_write(5'h0C, 32'hC0FFEE01, 4'hF, 5);
        expect_read(5'h04);
        drive_read(5'h04, 5);

        // Unmapped slots
        write_read(5'h10, 32'hCAFEBABE, 4'hF);
        write_read(5'h1C, 32'h5A5A5A5A, 4'hF);
        expect_read(5'h14);
        drive_read(5'h14, 0);
        check_regs("unmapped");

        // Simultaneous read and write of the same register
        expect_read(5'h08);
        expect_write(5'h08, 32'h55667788, 4'hF);
        fork
            drive_write(5'h08, 32'h55667788, 4'hF, 0);
            drive_read(5'h08, 0);
        join
        check_regs("simul");

        // Back-to-back writes
        expect_write(5'h00, 32'h00000001, 4'hF);
        drive_write(5'h00, 32'h00000001, 4'hF, 0);
        expect_write(5'h04, 32'h00000002, 4'hF);
        drive_write(5'h04, 32'h00000002, 4'hF, 0);
        check_regs("b2b");

        // Reset while in W_GOT_AW
        expect_write(5'h08, 32'hDEAD0011, 4'hF);
        drive_write(5'h08, 32'hDEAD0011, 4'hF, 0);
        check("pre_rst_reg2", reg2, 32'hDEAD0011);
        @(negedge clk);
        bus.S_AXI_AWADDR  = 5'h08;
        bus.S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!bus.S_AXI_AWREADY && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        check("rst_aw_bound", t < BOUND, 1'b1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        check("got_aw_awready", bus.S_AXI_AWREADY, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_awready", bus.S_AXI_AWREADY, 1'b0);
        check("arst_wready",  bus.S_AXI_WREADY,  1'b0);
        check("arst_arready", bus.S_AXI_ARREADY, 1'b0);
        check("arst_bvalid",  bus.S_AXI_BVALID,  1'b0);
        check("arst_rvalid",  bus.S_AXI_RVALID,  1'b0);
        check("arst_reg2",    reg2,              32'h0);
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        check_regs("arst");
        #10 rst_n = 1'b1;

        // Fresh traffic after reset
        write_read(5'h08, 32'h0BADF00D, 4'hF);
        write_read(5'h00, 32'h13572468, 4'hF);
        check_regs("post_rst");

        check("wq_drained", wq.size(), 32'd0);
        check("rq_drained", rq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_out_axil_regs.md
Name: audio_out_axil_regs

Overview:
AXI4-Lite responder register block for the audio_out peripheral. It is the slave end of the S00_AXI interface that the master BFM drives. It holds four 32-bit read/write control registers and presents them to the audio datapath. It accepts AW and W independently, honours byte strobes, and returns one B or R response per transaction with full VALID/READY back-pressure.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word slots, of which slots 0-3 are implemented.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
reg0_o..reg3_o  out  32 each  register contents to the audio datapath
wr_pulse_o  out  4  one-hot, one cycle high when register n is written

Behaviour:
- Single clock S_AXI_ACLK. Reset S_AXI_ARESETN is asynchronous and active-low.
- Reset values: all READY, VALID and wr_pulse_o outputs 0; all registers 0; BRESP/RRESP 2'b00; RDATA 0.
- Word index is ADDR[4:2]; ADDR[1:0] is ignored.
- Write FSM states: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
  - W_IDLE: AWREADY=WREADY=1.
    - AW and W handshake in the same cycle -> W_RESP.
    - AW only -> latch address, go to W_GOT_AW (WREADY stays 1, AWREADY=0).
    - W only -> latch data and strobes, go to W_GOT_W.
  - Register update occurs on the cycle both halves are held. BVALID rises the next cycle (write-to-BVALID latency is 1 cycle after the later of AW/W).
  - W_RESP: AWREADY=WREADY=0. BVALID is held until BREADY, then -> W_IDLE.
  - Back-to-back: a new AW/W is accepted in the cycle after B completes; no bubble beyond that cycle.
- Strobes: byte k is updated only if WSTRB[k]=1. WSTRB=0 completes with OKAY and changes nothing. wr_pulse_o still fires for that slot.
- Read FSM states: R_IDLE (ARREADY=1), R_RESP.
  - On AR handshake, RDATA is registered and RVALID rises the next cycle.
  - RDATA/RRESP are held stable until RREADY, then -> R_IDLE.
  - Unmapped slots 4-7 read 0.
- Simultaneous read and write to the same register: the read returns the pre-write value. Read and write channels are fully independent, with no mutual blocking.
- Write to an unmapped slot: data is discarded, no wr_pulse_o, response OKAY (unless the optional feature is enabled).
- Reset asserted mid-transaction: all FSMs return to IDLE immediately and registers clear. Any pending response is dropped.

Optional Feature:
AUDIO_OUT_SLVERR_EN.
- Defined: writes or reads to slots 4-7 return 2'b10 (SLVERR); reads return RDATA 0.
- Not defined: those accesses return 2'b00 (OKAY).
- In both cases there is no register side effect.

Decomposition:
- Shared package audio_out_pkg holds:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - the register index constants REG_CTRL=0, REG_VOL=1, REG_RATE=2, REG_AUX=3;
  - the FSM state enums.
- One natural sub-module: audio_out_strb_merge, combinational, producing (old, new, strb) -> merged word; it is instantiated per register write path.

Test Plan:
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011 and 0xbeef0011 to offsets 0x0, 0x4, 0x8 and 0xC, reading back after each write -> every BRESP/RRESP is 0 and each readback equals the written value; reg0_o..reg3_o match.
- AW issued 3 cycles before W to 0x4 with data 0x12345678 -> AWREADY low after the AW handshake; BVALID asserts 1 cycle after the W handshake; reg1_o=0x12345678; wr_pulse_o=4'b0010 for one cycle.
- Preload reg0=0xFFFFFFFF, then write 0x00AA0055 with WSTRB=4'b0101 -> readback 0xFFAAFF55.
- Hold BREADY low for 5 cycles after a write -> BVALID stays 1 with BRESP stable, and no new AW is accepted until B completes. Repeat for the read side with RREADY low: RDATA stays stable.
- Read 0x10 -> RDATA=0. RRESP=2'b00 without AUDIO_OUT_SLVERR_EN and 2'b10 with it; the write-side equivalent leaves reg0-reg3 unchanged.
- Assert S_AXI_ARESETN low asynchronously while in W_GOT_AW with reg2=0xdead0011 -> all VALID/READY outputs are 0 and reg2_o=0 immediately. After release, a fresh write/read sequence succeeds.
